// File: rtl/aes_block_loader.sv
// Byte-serial loader that assembles a 128-bit AES text block and key from a framed stream.
// Optional feature: define LOADER_KEY_REUSE_EN to add key_reuse (16-byte frames keep the previous key).
module aes_block_loader #(
  parameter  int N  = 128,
  localparam int NB = N / 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   in_byte,
  input  logic         in_valid,
  input  logic         in_sof,
`ifdef LOADER_KEY_REUSE_EN
  input  logic         key_reuse,
`endif
  output logic         in_ready,
  output logic [N-1:0] blk_text,
  output logic [N-1:0] blk_key,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic         err,
  output logic [4:0]   byte_cnt
);

  typedef enum logic [1:0] {
    SYNC      = 2'd0,
    LOAD_TEXT = 2'd1,
    LOAD_KEY  = 2'd2,
    PRESENT   = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [4:0]     cnt_q, cnt_d;
  logic [N-1:0]   text_q, text_d;
  logic [N-1:0]   key_q, key_d;
  logic           err_q, err_d;
  logic           accept;
  logic           short_frame;

`ifdef LOADER_KEY_REUSE_EN
  logic           reuse_q, reuse_d;
  assign short_frame = reuse_q;
`else
  assign short_frame = 1'b0;
`endif

  // Ready is decoded from registered state only, never from blk_ready.
  assign in_ready  = (state_q != PRESENT);
  assign blk_valid = (state_q == PRESENT);
  assign accept    = in_valid && in_ready;
  assign blk_text  = text_q;
  assign blk_key   = key_q;
  assign err       = err_q;
  assign byte_cnt  = cnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    text_d  = text_q;
    key_d   = key_q;
    err_d   = 1'b0;
`ifdef LOADER_KEY_REUSE_EN
    reuse_d = reuse_q;
`endif
    case (state_q)
      SYNC: begin
        if (accept) begin
          if (in_sof) begin
            text_d[N-1 -: 8] = in_byte;
            cnt_d            = 5'd1;
            state_d          = LOAD_TEXT;
`ifdef LOADER_KEY_REUSE_EN
            reuse_d          = key_reuse;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD_TEXT, LOAD_KEY: begin
        if (accept) begin
          if (in_sof) begin
            // Restart: stale bytes of the aborted frame are simply overwritten later.
            text_d[N-1 -: 8] = in_byte;
            cnt_d            = 5'd1;
            state_d          = LOAD_TEXT;
            err_d            = 1'b1;
`ifdef LOADER_KEY_REUSE_EN
            reuse_d          = key_reuse;
`endif
          end else if (state_q == LOAD_TEXT) begin
            // Byte i lands at bit offset 8*(15-i), and 15-i is the 4-bit complement of i.
            text_d[{~cnt_q[3:0], 3'b000} +: 8] = in_byte;
            if (cnt_q == 5'(NB - 1)) begin
              if (short_frame) begin
                cnt_d   = 5'd0;
                state_d = PRESENT;
              end else begin
                cnt_d   = 5'(NB);
                state_d = LOAD_KEY;
              end
            end else begin
              cnt_d = cnt_q + 5'd1;
            end
          end else begin
            key_d[{~cnt_q[3:0], 3'b000} +: 8] = in_byte;
            if (cnt_q == 5'(2 * NB - 1)) begin
              cnt_d   = 5'd0;
              state_d = PRESENT;
            end else begin
              cnt_d = cnt_q + 5'd1;
            end
          end
        end
      end
      PRESENT: begin
        if (blk_ready) begin
          state_d = SYNC;
        end
      end
      default: begin
        state_d = SYNC;
        cnt_d   = 5'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SYNC;
      cnt_q   <= 5'd0;
      text_q  <= '0;
      key_q   <= '0;
      err_q   <= 1'b0;
`ifdef LOADER_KEY_REUSE_EN
      reuse_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      text_q  <= text_d;
      key_q   <= key_d;
      err_q   <= err_d;
`ifdef LOADER_KEY_REUSE_EN
      reuse_q <= reuse_d;
`endif
    end
  end

endmodule

// File: tb/tb_aes_block_loader.sv
// Self-checking bench for aes_block_loader: directed FIPS-197 scenarios plus randomized traffic
// compared every cycle against a frame-position reference model.
module tb_aes_block_loader;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   in_byte;
  logic         in_valid;
  logic         in_sof;
  logic         in_ready;
  logic [127:0] blk_text;
  logic [127:0] blk_key;
  logic         blk_valid;
  logic         blk_ready;
  logic         err;
  logic [4:0]   byte_cnt;
`ifdef LOADER_KEY_REUSE_EN
  logic         key_reuse = 1'b0;
`endif

  int tests = 0;
  int fails = 0;
  int err_seen = 0;
  int blocks = 0;
  bit chk_en = 1'b0;

  // Reference model: frame position -1 = waiting for SOF, 0..31 = next byte, 32 = block held.
  int           m_pos = -1;
  logic         m_err = 1'b0;
  logic [127:0] m_text = '0;
  logic [127:0] m_key = '0;

  logic [127:0] fips_text = 128'h3243f6a8885a308d313198a2e0370734;
  logic [127:0] fips_key  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  aes_block_loader dut (
    .clk       (clk),
    .reset     (reset),
    .in_byte   (in_byte),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
`ifdef LOADER_KEY_REUSE_EN
    .key_reuse (key_reuse),
`endif
    .in_ready  (in_ready),
    .blk_text  (blk_text),
    .blk_key   (blk_key),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .err       (err),
    .byte_cnt  (byte_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_pos  = -1;
      m_err  = 1'b0;
      m_text = '0;
      m_key  = '0;
    end else begin
      m_err = 1'b0;
      if (m_pos == 32) begin
        if (blk_ready) m_pos = -1;
      end else if (in_valid) begin
        if (in_sof) begin
          m_err = (m_pos != -1);
          m_text[127 -: 8] = in_byte;
          m_pos = 1;
        end else if (m_pos == -1) begin
          m_err = 1'b1;
        end else begin
          if (m_pos < 16) m_text[127 - 8*m_pos -: 8] = in_byte;
          else            m_key[127 - 8*(m_pos-16) -: 8] = in_byte;
          m_pos++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",  128'(in_ready),  128'(m_pos != 32));
      chk("blk_valid", 128'(blk_valid), 128'(m_pos == 32));
      chk("byte_cnt",  128'(byte_cnt),  128'((m_pos < 0 || m_pos == 32) ? 0 : m_pos));
      chk("err",       128'(err),       128'(m_err));
      chk("blk_text",  blk_text, m_text);
      chk("blk_key",   blk_key,  m_key);
      if (err) err_seen++;
      if (blk_valid && blk_ready) begin
        blocks++;
        $display("[TB] block %0d taken text=%h key=%h", blocks, blk_text, blk_key);
      end
    end
  end

  task automatic drive(input logic [7:0] b, input logic sof);
    in_valid = 1'b1;
    in_byte  = b;
    in_sof   = sof;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_frame(input logic [127:0] t, input logic [127:0] k);
    for (int i = 0; i < 32; i++) begin
      if (i < 16) drive(t[127 - 8*i -: 8], i == 0);
      else        drive(k[127 - 8*(i-16) -: 8], 1'b0);
    end
  endtask

  initial begin
    int e0;
    reset = 1'b1; in_byte = '0; in_valid = 1'b0; in_sof = 1'b0; blk_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    reset  = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 128'(in_ready), 128'(1));
    chk("reset_byte_cnt", 128'(byte_cnt), 128'(0));
    chk("reset_valid",    128'(blk_valid), 128'(0));
    @(posedge clk); #1;

    // FIPS-197 frame, core always ready: valid for exactly one cycle right after byte 31.
    blk_ready = 1'b1;
    send_frame(fips_text, fips_key);
    @(negedge clk);
    chk("fips_valid", 128'(blk_valid), 128'(1));
    chk("fips_text",  blk_text, 128'h3243f6a8885a308d313198a2e0370734);
    chk("fips_key",   blk_key,  128'h2b7e151628aed2a6abf7158809cf4f3c);
    @(negedge clk);
    chk("fips_valid_one_cycle", 128'(blk_valid), 128'(0));
    @(posedge clk); #1;

    // Backpressure: bytes offered while the block is held are refused.
    blk_ready = 1'b0;
    send_frame(fips_key, fips_text);
    for (int i = 0; i < 10; i++) begin
      drive(8'h55, 1'b1);
      chk("bp_in_ready", 128'(in_ready), 128'(0));
      chk("bp_text",     blk_text, fips_key);
    end
    blk_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_release_valid", 128'(blk_valid), 128'(0));
    chk("bp_release_ready", 128'(in_ready), 128'(1));
    @(posedge clk); #1;

    // Mid-frame restart at byte_cnt 20.
    e0 = err_seen;
    for (int i = 0; i < 20; i++) drive(8'($urandom), i == 0);
    send_frame(fips_text, fips_key);
    @(negedge clk);
    chk("restart_valid", 128'(blk_valid), 128'(1));
    chk("restart_text",  blk_text, fips_text);
    chk("restart_key",   blk_key,  fips_key);
    chk("restart_err_pulses", 128'(err_seen - e0), 128'(1));
    @(posedge clk); #1;

    // Stray byte without SOF while synchronising.
    drive(8'hAA, 1'b0);
    @(negedge clk);
    chk("nosof_err",      128'(err), 128'(1));
    chk("nosof_byte_cnt", 128'(byte_cnt), 128'(0));
    chk("nosof_text",     blk_text, fips_text);
    @(negedge clk);
    chk("nosof_err_pulse", 128'(err), 128'(0));
    @(posedge clk); #1;

    // Synchronous reset partway through a frame.
    for (int i = 0; i < 9; i++) drive(8'($urandom), i == 0);
    @(negedge clk);
    chk("pre_reset_cnt", 128'(byte_cnt), 128'(9));
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset9_cnt",   128'(byte_cnt), 128'(0));
    chk("reset9_valid", 128'(blk_valid), 128'(0));
    chk("reset9_text",  blk_text, 128'h0);
    @(posedge clk); #1;
    send_frame(fips_text, fips_key);
    @(negedge clk);
    chk("post_reset_text", blk_text, fips_text);
    chk("post_reset_key",  blk_key,  fips_key);
    @(posedge clk); #1;

    // Randomized traffic with occasional SOF, stalls, backpressure and resets.
    for (int c = 0; c < 4000; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_sof    = ($urandom_range(39) == 0) || (m_pos == -1 && $urandom_range(3) == 0);
      in_byte   = 8'($urandom);
      blk_ready = ($urandom_range(2) == 0);
      reset     = ($urandom_range(599) == 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_sof = 1'b0; reset = 1'b0; blk_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
